switch_seq_ctrl: RTL

SWITCH_SEQ_CTRL -- requirements
Module: switch_seq_ctrl

---
 rtl/switch_seq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/switch_seq_ctrl.sv
// Round-robin switch sequencer: arbitrates 4 requesters, pulses the switch,
// holds the lock window (with the extra gap on an 11->00 move) and reports done/gnt.
module switch_seq_ctrl #(
  parameter int NORM_LOCK = 2,
  parameter int LONG_LOCK = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       switch_enb,
  output logic [1:0] switch_select,
  output logic [1:0] lock_enb,
  output logic       done,
  output logic [3:0] gnt,
  output logic       busy
);

  if (NORM_LOCK < 1 || NORM_LOCK > 2) begin : g_bad_norm
    $error("switch_seq_ctrl: NORM_LOCK must be 1..2");
  end
  if (LONG_LOCK < 1 || LONG_LOCK > 10) begin : g_bad_long
    $error("switch_seq_ctrl: LONG_LOCK must be 1..10");
  end

  localparam logic [3:0] NORM_LD = 4'(NORM_LOCK - 1);
  localparam logic [3:0] LONG_LD = 4'(LONG_LOCK - 1);

  typedef enum logic [1:0] {IDLE, GAP, LOCK, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       long_q, long_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic       enb_q, enb_d;
  logic [1:0] lock_q, lock_d;
  logic       done_q, done_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic [1:0] win;
  logic       win_vld;
  logic       arb;

  // Priority search starts one past the last granted index and wraps.
  always_comb begin
    logic [1:0] idx;
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign arb = (state_q == IDLE) && win_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      long_q  <= 1'b0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      enb_q   <= 1'b0;
      lock_q  <= 2'b00;
      done_q  <= 1'b0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      enb_q   <= enb_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (arb) begin
          last_d = win;
          // sel_q still holds the previous selection here
          if (win == 2'd0 && sel_q == 2'd3) begin
            state_d = GAP;
            long_d  = 1'b1;
          end else begin
            state_d = LOCK;
            long_d  = 1'b0;
            cnt_d   = NORM_LD;
          end
        end
      end
      GAP: begin
        state_d = LOCK;
        cnt_d   = LONG_LD;
      end
      LOCK: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so every port comes straight from a flop.
  always_comb begin
    sel_d  = arb ? win : sel_q;
    enb_d  = arb;
    lock_d = 2'b00;
    if (state_d == LOCK) lock_d = long_d ? 2'b10 : 2'b01;
    done_d = (state_d == DONE);
    gnt_d  = done_d ? (4'b0001 << sel_q) : 4'b0000;
    busy_d = (state_d != IDLE);
  end

  assign switch_enb    = enb_q;
  assign switch_select = sel_q;
  assign lock_enb      = lock_q;
  assign done          = done_q;
  assign gnt           = gnt_q;
  assign busy          = busy_q;

endmodule
